// File: rtl/a25_wishbone_slave_mem_if.sv
// Wishbone B3 classic bundle between the Amber 128-bit master port and a memory slave.
interface a25_wishbone_slave_mem_if;
    logic [31:0]  i_wb_adr;
    logic [15:0]  i_wb_sel;
    logic         i_wb_we;
    logic [127:0] i_wb_dat;
    logic         i_wb_cyc;
    logic         i_wb_stb;
    logic [127:0] o_wb_dat;
    logic         o_wb_ack;
    logic         o_wb_err;

    modport master (
        output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );
    modport slave (
        input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
        output o_wb_dat, o_wb_ack, o_wb_err
    );
endinterface

// File: rtl/a25_wishbone_slave_mem.sv
// Wishbone classic slave in front of a fixed-latency 128-bit single-port SRAM.
// One transaction in flight; every output comes straight from a register.
module a25_wishbone_slave_mem #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          ERR_EN       = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    a25_wishbone_slave_mem_if.slave wb,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [ADDR_W-1:0]       o_mem_addr,
    output logic [15:0]             o_mem_be,
    output logic [127:0]            o_mem_wdata,
    input  logic [127:0]            i_mem_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RD_WAIT, S_ACK, S_ERR} state_e;

    // 33-bit window bounds so a window ending at 2^32 does not wrap to zero
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd16 << ADDR_W);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d, err_q, err_d;
    logic                en_q, en_d, mwe_q, mwe_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [15:0]         be_q, be_d;
    logic [127:0]        wdata_q, wdata_d, rdat_q, rdat_d;

    logic [32:0]         adr_ext;
    logic                in_win, req;
    logic [ADDR_W-1:0]   word_addr;
    logic                unused_nibble;

    assign adr_ext       = {1'b0, wb.i_wb_adr};
    assign in_win        = (adr_ext >= WIN_LO) && (adr_ext < WIN_HI);
    assign req           = wb.i_wb_cyc && wb.i_wb_stb;
    // base is 16-byte aligned, so subtracting only the word bits loses no borrow
    assign word_addr     = wb.i_wb_adr[ADDR_W+3:4] - BASE_ADDR[ADDR_W+3:4];
    assign unused_nibble = ^wb.i_wb_adr[3:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        en_d    = 1'b0;
        mwe_d   = 1'b0;
        maddr_d = '0;
        be_d    = '0;
        wdata_d = '0;
        rdat_d  = rdat_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (in_win || !ERR_EN) begin
                        state_d = S_ACCESS;
                        en_d    = 1'b1;
                        mwe_d   = wb.i_wb_we;
                        maddr_d = word_addr;
                        be_d    = wb.i_wb_we ? wb.i_wb_sel : 16'h0000;
                        wdata_d = wb.i_wb_dat;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            // mwe_q still holds the latched direction while the access is on the SRAM port
            S_ACCESS: begin
                if (!wb.i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (mwe_q) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                end else begin
                    state_d = S_RD_WAIT;
                    cnt_d   = 3'(READ_LATENCY);
                end
            end
            S_RD_WAIT: begin
                if (!wb.i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 3'd1) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    rdat_d  = i_mem_rdata;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            mwe_q   <= 1'b0;
            maddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            en_q    <= en_d;
            mwe_q   <= mwe_d;
            maddr_q <= maddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdat_q  <= rdat_d;
        end
    end

    assign wb.o_wb_dat = rdat_q;
    assign wb.o_wb_ack = ack_q;
    assign wb.o_wb_err = err_q;
    assign o_mem_en    = en_q;
    assign o_mem_we    = mwe_q;
    assign o_mem_addr  = maddr_q;
    assign o_mem_be    = be_q;
    assign o_mem_wdata = wdata_q;
endmodule

// File: tb/tb_a25_wishbone_slave_mem.sv
// Two slaves share one bus stimulus: A (base 0, err on miss, latency 3) and
// B (base 0x4800, wrapping, latency 1); results are scored against a byte-level memory model.
module tb_a25_wishbone_slave_mem;
    localparam int          RLA    = 3;
    localparam int          RLB    = 1;
    localparam logic [31:0] BASE_B = 32'h0000_4800;
    localparam logic [31:0] SALT_A = 32'h1357_9BDF;
    localparam logic [31:0] SALT_B = 32'h2468_ACE0;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;
    always #5 i_clk = ~i_clk;

    logic [31:0]  adr;
    logic [15:0]  sel;
    logic         we;
    logic [127:0] dat;
    logic         cyc_a, stb_a, cyc_b, stb_b;

    a25_wishbone_slave_mem_if ifa ();
    a25_wishbone_slave_mem_if ifb ();
    assign ifa.i_wb_adr = adr;   assign ifb.i_wb_adr = adr;
    assign ifa.i_wb_sel = sel;   assign ifb.i_wb_sel = sel;
    assign ifa.i_wb_we  = we;    assign ifb.i_wb_we  = we;
    assign ifa.i_wb_dat = dat;   assign ifb.i_wb_dat = dat;
    assign ifa.i_wb_cyc = cyc_a; assign ifb.i_wb_cyc = cyc_b;
    assign ifa.i_wb_stb = stb_a; assign ifb.i_wb_stb = stb_b;

    logic         en_a, mwe_a, en_b, mwe_b;
    logic [9:0]   maddr_a, maddr_b;
    logic [15:0]  be_a, be_b;
    logic [127:0] wd_a, wd_b, rd_a, rd_b;

    a25_wishbone_slave_mem #(.BASE_ADDR(32'h0), .ADDR_W(10), .READ_LATENCY(RLA), .ERR_EN(1'b1)) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .wb(ifa),
        .o_mem_en(en_a), .o_mem_we(mwe_a), .o_mem_addr(maddr_a), .o_mem_be(be_a),
        .o_mem_wdata(wd_a), .i_mem_rdata(rd_a));

    a25_wishbone_slave_mem #(.BASE_ADDR(BASE_B), .ADDR_W(10), .READ_LATENCY(RLB), .ERR_EN(1'b0)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .wb(ifb),
        .o_mem_en(en_b), .o_mem_we(mwe_b), .o_mem_addr(maddr_b), .o_mem_be(be_b),
        .o_mem_wdata(wd_b), .i_mem_rdata(rd_b));

    // Power-up contents of a never-written SRAM word
    function automatic logic [127:0] initval(input logic [31:0] w, input logic [31:0] salt);
        return {(w * 32'h9E37_79B9) ^ salt, ~w, w + salt, 32'hA25A_0000 ^ w};
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                           input logic [15:0] be);
        logic [127:0] r;
        r = old;
        for (int i = 0; i < 16; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // SRAM behind A: fixed read latency RLA, junk on the data bus when no read is due
    logic [127:0] sram_a [1024];
    bit           wr_a   [1024];
    logic [127:0] pipe_a [RLA];
    always @(posedge i_clk) begin
        if (en_a && mwe_a) begin
            sram_a[maddr_a] <= merge(wr_a[maddr_a] ? sram_a[maddr_a] : initval({22'd0, maddr_a}, SALT_A), wd_a, be_a);
            wr_a[maddr_a]   <= 1'b1;
        end
        pipe_a[0] <= (en_a && !mwe_a) ? (wr_a[maddr_a] ? sram_a[maddr_a] : initval({22'd0, maddr_a}, SALT_A))
                                      : {4{$urandom}};
        for (int i = 1; i < RLA; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign rd_a = pipe_a[RLA-1];

    logic [127:0] sram_b [1024];
    bit           wr_b   [1024];
    always @(posedge i_clk) begin
        if (en_b && mwe_b) begin
            sram_b[maddr_b] <= merge(wr_b[maddr_b] ? sram_b[maddr_b] : initval({22'd0, maddr_b}, SALT_B), wd_b, be_b);
            wr_b[maddr_b]   <= 1'b1;
        end
        rd_b <= (en_b && !mwe_b) ? (wr_b[maddr_b] ? sram_b[maddr_b] : initval({22'd0, maddr_b}, SALT_B))
                                 : {4{$urandom}};
    end

    // Reference: byte-addressed memory per slave, keyed id*2^20 + word*16 + lane
    logic [7:0]   refm [int];
    logic [127:0] last_a, last_b;
    int n_chk = 0;
    int n_err = 0;

    function automatic logic [127:0] ref_rd(input int id, input logic [31:0] w);
        logic [127:0] iv, r;
        iv = initval(w, (id == 0) ? SALT_A : SALT_B);
        r  = '0;
        for (int l = 0; l < 16; l++) begin
            int k;
            k = id * 1048576 + int'(w) * 16 + l;
            r[8*l +: 8] = refm.exists(k) ? refm[k] : iv[8*l +: 8];
        end
        return r;
    endfunction

    task automatic ref_wr(input int id, input logic [31:0] w, input logic [127:0] d, input logic [15:0] s);
        for (int l = 0; l < 16; l++) if (s[l]) refm[id * 1048576 + int'(w) * 16 + l] = d[8*l +: 8];
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One classic transaction on both slaves; each master drops cyc/stb on its own ack/err.
    task automatic xact(input logic [31:0] a, input logic w, input logic [15:0] s, input logic [127:0] d);
        logic         in_a;
        logic [31:0]  wa, wbw;
        logic [127:0] ea, eb;
        int a_ack = 0, a_err = 0, a_en = 0, a_ackk = 0, a_errk = 0, a_enk = 0;
        int b_ack = 0, b_err = 0, b_en = 0, b_ackk = 0, b_enk = 0;
        logic [9:0]   a_ad = '0, b_ad = '0;
        logic         a_mw = 1'b0, b_mw = 1'b0;
        logic [15:0]  a_be = '0, b_be = '0;
        logic [127:0] a_wd = '0, b_wd = '0;
        in_a = a < 32'h0000_4000;
        wa   = (a >> 4) & 32'h3FF;
        wbw  = ((a - BASE_B) >> 4) & 32'h3FF;
        ea   = (in_a && !w) ? ref_rd(0, wa) : last_a;
        eb   = !w ? ref_rd(1, wbw) : last_b;
        if (w) begin
            if (in_a) ref_wr(0, wa, d, s);
            ref_wr(1, wbw, d, s);
        end
        adr = a; we = w; sel = s; dat = d;
        cyc_a = 1'b1; stb_a = 1'b1; cyc_b = 1'b1; stb_b = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge i_clk); #1;
            if (ifa.o_wb_ack) begin a_ack++; a_ackk = k; end
            if (ifa.o_wb_err) begin a_err++; a_errk = k; end
            if (ifa.o_wb_ack || ifa.o_wb_err) begin cyc_a = 1'b0; stb_a = 1'b0; end
            if (en_a) begin a_en++; a_enk = k; a_ad = maddr_a; a_mw = mwe_a; a_be = be_a; a_wd = wd_a; end
            if (ifb.o_wb_ack) begin b_ack++; b_ackk = k; end
            if (ifb.o_wb_err) b_err++;
            if (ifb.o_wb_ack || ifb.o_wb_err) begin cyc_b = 1'b0; stb_b = 1'b0; end
            if (en_b) begin b_en++; b_enk = k; b_ad = maddr_b; b_mw = mwe_b; b_be = be_b; b_wd = wd_b; end
        end
        cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
        chk("a_ack_count", 128'(a_ack), 128'(in_a));
        chk("a_err_count", 128'(a_err), 128'(!in_a));
        chk("a_en_count",  128'(a_en),  128'(in_a));
        if (in_a) begin
            chk("a_ack_cycle", 128'(a_ackk), 128'(w ? 2 : 2 + RLA));
            chk("a_en_cycle",  128'(a_enk), 128'(1));
            chk("a_mem_addr",  128'(a_ad), 128'(wa));
            chk("a_mem_we",    128'(a_mw), 128'(w));
            chk("a_mem_be",    128'(a_be), 128'(w ? s : 16'h0));
            if (w) chk("a_mem_wdata", a_wd, d);
        end else begin
            chk("a_err_cycle", 128'(a_errk), 128'(1));
        end
        chk("a_wb_dat", ifa.o_wb_dat, ea);
        chk("b_ack_count", 128'(b_ack), 128'(1));
        chk("b_err_count", 128'(b_err), 128'(0));
        chk("b_en_count",  128'(b_en), 128'(1));
        chk("b_ack_cycle", 128'(b_ackk), 128'(w ? 2 : 2 + RLB));
        chk("b_en_cycle",  128'(b_enk), 128'(1));
        chk("b_mem_addr",  128'(b_ad), 128'(wbw));
        chk("b_mem_we",    128'(b_mw), 128'(w));
        chk("b_mem_be",    128'(b_be), 128'(w ? s : 16'h0));
        if (w) chk("b_mem_wdata", b_wd, d);
        chk("b_wb_dat", ifb.o_wb_dat, eb);
        last_a = ea;
        last_b = eb;
    endtask

    initial begin
        logic [127:0] x;
        logic [31:0]  ra;
        logic [8:0]   enm, ackm;
        int           n_ack, n_erp, n_en, r;
        adr = '0; sel = '0; we = 1'b0; dat = '0;
        cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
        last_a = '0; last_b = '0;

        // reset state
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_a_ack", 128'(ifa.o_wb_ack), 128'(0));
        chk("rst_a_err", 128'(ifa.o_wb_err), 128'(0));
        chk("rst_a_en",  128'(en_a), 128'(0));
        chk("rst_a_we",  128'(mwe_a), 128'(0));
        chk("rst_a_addr", 128'(maddr_a), 128'(0));
        chk("rst_a_be",  128'(be_a), 128'(0));
        chk("rst_a_wdata", wd_a, 128'(0));
        chk("rst_a_dat", ifa.o_wb_dat, 128'(0));
        chk("rst_b_ack", 128'(ifb.o_wb_ack), 128'(0));
        chk("rst_b_dat", ifb.o_wb_dat, 128'(0));
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // directed: partial write, write-then-read, window edges, sel=0 write
        xact(32'h10, 1'b1, 16'h000F, {16{8'hA5}});
        xact(32'h20, 1'b1, 16'hFFFF, 128'h1234);
        xact(32'h20, 1'b0, 16'h0000, 128'h0);
        xact(32'h0000_4000, 1'b0, 16'h0000, 128'h0);
        xact(32'h0000_3FF8, 1'b0, 16'h0000, 128'h0);
        xact(32'hFFFF_FFF0, 1'b1, 16'hFFFF, {4{32'hDEAD_BEEF}});
        xact(32'h40, 1'b1, 16'h0000, {4{32'hCAFE_F00D}});
        xact(32'h40, 1'b0, 16'h0000, 128'h0);
        xact(32'h20, 1'b0, 16'h0000, 128'h0);

        // read aborted by dropping cyc in the latency wait
        n_ack = 0; n_erp = 0; n_en = 0;
        adr = 32'h40; we = 1'b0; sel = '0; cyc_a = 1'b1; stb_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge i_clk); #1;
            if (ifa.o_wb_ack) n_ack++;
            if (ifa.o_wb_err) n_erp++;
            if (en_a) n_en++;
            if (k == 2) begin cyc_a = 1'b0; stb_a = 1'b0; end
        end
        chk("abort_ack", 128'(n_ack), 128'(0));
        chk("abort_err", 128'(n_erp), 128'(0));
        chk("abort_en",  128'(n_en), 128'(1));
        chk("abort_dat", ifa.o_wb_dat, last_a);
        xact(32'h30, 1'b1, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});

        // reset asserted while a read waits on the SRAM
        adr = 32'h50; we = 1'b0; cyc_a = 1'b1; stb_a = 1'b1;
        repeat (2) begin @(posedge i_clk); #1; end
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_a_ack", 128'(ifa.o_wb_ack), 128'(0));
        chk("midrst_a_en",  128'(en_a), 128'(0));
        chk("midrst_a_addr", 128'(maddr_a), 128'(0));
        chk("midrst_a_wdata", wd_a, 128'(0));
        chk("midrst_a_dat", ifa.o_wb_dat, 128'(0));
        chk("midrst_b_dat", ifb.o_wb_dat, 128'(0));
        cyc_a = 1'b0; stb_a = 1'b0;
        @(posedge i_clk); #1 i_rst_n = 1'b1;
        last_a = '0; last_b = '0;
        xact(32'h0, 1'b0, 16'h0000, 128'h0);

        // stb held across ack: low nibble ignored, next transaction sampled right after ack
        x = {$urandom, $urandom, $urandom, $urandom};
        ref_wr(0, 32'd1, x, 16'hFFFF);
        enm = '0; ackm = '0;
        adr = 32'h1F; we = 1'b1; sel = 16'hFFFF; dat = x; cyc_a = 1'b1; stb_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge i_clk); #1;
            if (ifa.o_wb_ack) ackm[k] = 1'b1;
            if (en_a) begin
                enm[k] = 1'b1;
                chk("b2b_addr", 128'(maddr_a), 128'(1));
            end
            if (k == 5) begin cyc_a = 1'b0; stb_a = 1'b0; end
        end
        chk("b2b_en_mask",  128'(enm),  128'(9'h012));
        chk("b2b_ack_mask", 128'(ackm), 128'(9'h024));
        xact(32'h10, 1'b0, 16'h0000, 128'h0);

        // randomized mix of reused words, whole window and out-of-window addresses
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)      ra = 32'(($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
            else if (r < 8) ra = 32'($urandom_range(0, 32'h3FFF));
            else            ra = $urandom | 32'h0000_4000;
            xact(ra, 1'($urandom_range(0, 1)), (r == 9) ? 16'h0000 : 16'($urandom),
                 {$urandom, $urandom, $urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
